wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/mips32_pkg.sv | 25 ++
 rtl/wb_fifo.sv | 69 ++++++
 rtl/wb_arbiter.sv | 114 +++++++++++
 tb/tb_wb_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips32_pkg.sv
// Shared register-file types for the writeback path: address/data widths,
// the buffered writeback record and the writeback source selector.
package mips32_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_PIPE = 2'd1,
        SRC_FIFO = 2'd2
    } wb_src_t;

    // Register 0 is hardwired to zero, so nothing targeting it is ever written or tracked.
    function automatic logic isWritable(input logic [REG_ADDR_W-1:0] addr);
        return addr != '0;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small result buffer for multiply/divide writebacks; DEPTH entries, strict FIFO order.
// Push and pop in the same cycle both take effect.
module wb_fifo
    import mips32_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  logic      pop,
    input  wb_entry_t pushEntry,
    output logic      full,
    output logic      empty,
    output wb_entry_t head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [CNT_W-1:0] count;
    logic             doPush;
    logic             doPop;

    assign full   = (count == FULL_CNT);
    assign empty  = (count == '0);
    assign doPush = push && !full;
    assign doPop  = pop && !empty;
    assign head   = mem[rdPtr];

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_IDX) ? '0 : ptr + PTR_ONE;
    endfunction

    // Storage itself needs no reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= pushEntry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= nextPtr(wrPtr);
            end
            if (doPop) begin
                rdPtr <= nextPtr(rdPtr);
            end
            unique case ({doPush, doPop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter between the main pipeline and buffered MDU results,
// with a busy scoreboard for decode hazards. Define WB_FAIRNESS_EN to let a full FIFO stall the pipeline.
module wb_arbiter
    import mips32_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pipeValid,
    input  logic [REG_ADDR_W-1:0] pipeAddr,
    input  logic [DATA_W-1:0]     pipeData,
    input  logic                  mduIssue,
    input  logic [REG_ADDR_W-1:0] mduIssueAddr,
    input  logic                  mduValid,
    input  logic [REG_ADDR_W-1:0] mduAddr,
    input  logic [DATA_W-1:0]     mduData,
    output logic                  mduReady,
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [REG_ADDR_W-1:0] rt,
    output logic                  hazStall,
    output logic                  pipeStall,
    output logic                  regWrite,
    output logic [REG_ADDR_W-1:0] rWriteAddress,
    output logic [DATA_W-1:0]     rWriteValue
);

    logic                fifoFull;
    logic                fifoEmpty;
    logic                fifoPush;
    logic                fifoPop;
    wb_entry_t           fifoHead;
    wb_entry_t           pushEntry;
    wb_entry_t           selEntry;
    wb_src_t             src;
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busySet;
    logic [NUM_REGS-1:0] busyClr;

    assign mduReady  = !fifoFull;
    assign fifoPush  = mduValid && mduReady;
    assign pushEntry = '{addr: mduAddr, data: mduData};
    assign fifoPop   = (src == SRC_FIFO);

    wb_fifo #(
        .DEPTH(DEPTH)
    ) uFifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifoPush),
        .pop      (fifoPop),
        .pushEntry(pushEntry),
        .full     (fifoFull),
        .empty    (fifoEmpty),
        .head     (fifoHead)
    );

`ifdef WB_FAIRNESS_EN
    // A full buffer takes the port so MDU results cannot be starved indefinitely.
    assign pipeStall = fifoFull;
`else
    assign pipeStall = 1'b0;
`endif

    always_comb begin
        src      = SRC_NONE;
        selEntry = '0;
        if (pipeValid && !pipeStall) begin
            src      = SRC_PIPE;
            selEntry = '{addr: pipeAddr, data: pipeData};
        end else if (!fifoEmpty) begin
            src      = SRC_FIFO;
            selEntry = fifoHead;
        end
    end

    // Address and value hold when idle so the register-file port does not toggle needlessly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regWrite      <= 1'b0;
            rWriteAddress <= '0;
            rWriteValue   <= '0;
        end else begin
            regWrite <= (src != SRC_NONE) && isWritable(selEntry.addr);
            if (src != SRC_NONE) begin
                rWriteAddress <= selEntry.addr;
                rWriteValue   <= selEntry.data;
            end
        end
    end

    always_comb begin
        busySet = '0;
        busyClr = '0;
        if (mduIssue && isWritable(mduIssueAddr)) begin
            busySet[mduIssueAddr] = 1'b1;
        end
        if ((src == SRC_FIFO) && isWritable(fifoHead.addr)) begin
            busyClr[fifoHead.addr] = 1'b1;
        end
    end

    // Set is applied after clear so a re-issue to the same register stays pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= (busy & ~busyClr) | busySet;
        end
    end

    assign hazStall = (isWritable(rs) && busy[rs]) || (isWritable(rt) && busy[rt]);

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter; expectations adapt to WB_FAIRNESS_EN.
module tb_wb_arbiter;

    localparam int DEPTH = 2;
`ifdef WB_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pipeValid;
    logic [4:0]  pipeAddr;
    logic [31:0] pipeData;
    logic        mduIssue;
    logic [4:0]  mduIssueAddr;
    logic        mduValid;
    logic [4:0]  mduAddr;
    logic [31:0] mduData;
    logic        mduReady;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        hazStall;
    logic        pipeStall;
    logic        regWrite;
    logic [4:0]  rWriteAddress;
    logic [31:0] rWriteValue;

    int compared = 0;
    int mismatched = 0;

    wb_arbiter #(
        .DEPTH(DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pipeValid    (pipeValid),
        .pipeAddr     (pipeAddr),
        .pipeData     (pipeData),
        .mduIssue     (mduIssue),
        .mduIssueAddr (mduIssueAddr),
        .mduValid     (mduValid),
        .mduAddr      (mduAddr),
        .mduData      (mduData),
        .mduReady     (mduReady),
        .rs           (rs),
        .rt           (rt),
        .hazStall     (hazStall),
        .pipeStall    (pipeStall),
        .regWrite     (regWrite),
        .rWriteAddress(rWriteAddress),
        .rWriteValue  (rWriteValue)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        pipeValid = 0; pipeAddr = 0; pipeData = 0;
        mduIssue = 0; mduIssueAddr = 0;
        mduValid = 0; mduAddr = 0; mduData = 0;
        rs = 0; rt = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clearInputs();
        step();
        step();
        compared++; if (regWrite !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_regWrite: got %0h, expected 0", regWrite); end
        compared++; if (rWriteAddress !== 5'd0) begin mismatched++; $display("[TB] FAIL reset_addr: got %0h, expected 0", rWriteAddress); end
        compared++; if (rWriteValue !== 32'd0) begin mismatched++; $display("[TB] FAIL reset_value: got %0h, expected 0", rWriteValue); end
        compared++; if (mduReady !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_mduReady: got %0h, expected 1", mduReady); end
        compared++; if (hazStall !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_hazStall: got %0h, expected 0", hazStall); end
        compared++; if (pipeStall !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_pipeStall: got %0h, expected 0", pipeStall); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_mdu_write();
        clearInputs();
        mduValid = 1; mduAddr = 5; mduData = 32'hDEADBEEF;
        step();
        mduValid = 0;
        compared++; if (regWrite !== 1'b0) begin mismatched++; $display("[TB] FAIL mdu_push_cycle: got regWrite %0h, expected 0", regWrite); end
        step();
        compared++; if (regWrite !== 1'b1) begin mismatched++; $display("[TB] FAIL mdu_regWrite: got %0h, expected 1", regWrite); end
        compared++; if (rWriteAddress !== 5'd5) begin mismatched++; $display("[TB] FAIL mdu_addr: got %0h, expected 5", rWriteAddress); end
        compared++; if (rWriteValue !== 32'hDEADBEEF) begin mismatched++; $display("[TB] FAIL mdu_value: got %0h, expected deadbeef", rWriteValue); end
        step();
        compared++; if (regWrite !== 1'b0) begin mismatched++; $display("[TB] FAIL idle_regWrite: got %0h, expected 0", regWrite); end
        compared++; if (rWriteAddress !== 5'd5 || rWriteValue !== 32'hDEADBEEF) begin mismatched++; $display("[TB] FAIL idle_hold: got %0h/%0h, expected 5/deadbeef", rWriteAddress, rWriteValue); end
    endtask

    task automatic test_priority();
        clearInputs();
        mduValid = 1; mduAddr = 7; mduData = 32'h77;
        step();
        mduValid = 0;
        pipeValid = 1; pipeAddr = 3; pipeData = 32'h11;
        step();
        pipeValid = 0;
        compared++; if (regWrite !== 1'b1 || rWriteAddress !== 5'd3 || rWriteValue !== 32'h11) begin mismatched++; $display("[TB] FAIL prio_pipe_first: got %0h/%0h/%0h, expected 1/3/11", regWrite, rWriteAddress, rWriteValue); end
        step();
        compared++; if (regWrite !== 1'b1 || rWriteAddress !== 5'd7 || rWriteValue !== 32'h77) begin mismatched++; $display("[TB] FAIL prio_fifo_next: got %0h/%0h/%0h, expected 1/7/77", regWrite, rWriteAddress, rWriteValue); end
        step();
        compared++; if (regWrite !== 1'b0) begin mismatched++; $display("[TB] FAIL prio_drained: got %0h, expected 0", regWrite); end
    endtask

    task automatic test_hazard();
        clearInputs();
        mduIssue = 1; mduIssueAddr = 9; rs = 9;
        step();
        mduIssue = 0;
        compared++; if (hazStall !== 1'b1) begin mismatched++; $display("[TB] FAIL haz_set: got %0h, expected 1", hazStall); end
        step();
        rs = 0; rt = 9; #1;
        compared++; if (hazStall !== 1'b1) begin mismatched++; $display("[TB] FAIL haz_rt: got %0h, expected 1", hazStall); end
        rs = 3; rt = 0; #1;
        compared++; if (hazStall !== 1'b0) begin mismatched++; $display("[TB] FAIL haz_other_reg: got %0h, expected 0", hazStall); end
        rs = 9;
        mduValid = 1; mduAddr = 9; mduData = 32'h99;
        step();
        mduValid = 0;
        compared++; if (hazStall !== 1'b1 || regWrite !== 1'b0) begin mismatched++; $display("[TB] FAIL haz_before_write: got haz %0h wr %0h, expected 1/0", hazStall, regWrite); end
        step();
        compared++; if (regWrite !== 1'b1 || rWriteAddress !== 5'd9 || hazStall !== 1'b0) begin mismatched++; $display("[TB] FAIL haz_cleared: got wr %0h addr %0h haz %0h, expected 1/9/0", regWrite, rWriteAddress, hazStall); end
        // Set and clear of register 10 on the same edge: set must win.
        mduIssue = 1; mduIssueAddr = 10; rs = 10;
        step();
        mduIssue = 0;
        mduValid = 1; mduAddr = 10; mduData = 32'h1010;
        step();
        mduValid = 0;
        mduIssue = 1; mduIssueAddr = 10;
        step();
        mduIssue = 0;
        compared++; if (regWrite !== 1'b1 || rWriteAddress !== 5'd10 || hazStall !== 1'b1) begin mismatched++; $display("[TB] FAIL haz_set_wins: got wr %0h addr %0h haz %0h, expected 1/10/1", regWrite, rWriteAddress, hazStall); end
        mduValid = 1; mduAddr = 10; mduData = 32'h2020;
        step();
        mduValid = 0;
        step();
        compared++; if (hazStall !== 1'b0 || rWriteValue !== 32'h2020) begin mismatched++; $display("[TB] FAIL haz_second_clear: got haz %0h val %0h, expected 0/2020", hazStall, rWriteValue); end
    endtask

    task automatic test_full();
        clearInputs();
        pipeValid = 1; pipeAddr = 1; pipeData = 32'hA0;
        mduValid = 1; mduAddr = 11; mduData = 32'hB11;
        step();
        mduAddr = 12; mduData = 32'hB12;
        step();
        compared++; if (mduReady !== 1'b0) begin mismatched++; $display("[TB] FAIL full_mduReady: got %0h, expected 0", mduReady); end
        compared++; if (pipeStall !== FAIR) begin mismatched++; $display("[TB] FAIL full_pipeStall: got %0h, expected %0h", pipeStall, FAIR); end
        mduAddr = 13; mduData = 32'hB13;
        step();
        mduValid = 0;
        compared++; if (regWrite !== 1'b1 || rWriteAddress !== (FAIR ? 5'd11 : 5'd1) || rWriteValue !== (FAIR ? 32'hB11 : 32'hA0)) begin mismatched++; $display("[TB] FAIL full_select: got %0h/%0h/%0h, expected 1/%0h/%0h", regWrite, rWriteAddress, rWriteValue, FAIR ? 5'd11 : 5'd1, FAIR ? 32'hB11 : 32'hA0); end
        compared++; if (mduReady !== FAIR) begin mismatched++; $display("[TB] FAIL full_after_drain_ready: got %0h, expected %0h", mduReady, FAIR); end
        compared++; if (pipeStall !== 1'b0) begin mismatched++; $display("[TB] FAIL full_stall_release: got %0h, expected 0", pipeStall); end
        pipeValid = 0;
        step();
        compared++; if (regWrite !== 1'b1 || rWriteAddress !== (FAIR ? 5'd12 : 5'd11)) begin mismatched++; $display("[TB] FAIL full_drain1: got %0h/%0h, expected 1/%0h", regWrite, rWriteAddress, FAIR ? 5'd12 : 5'd11); end
        step();
        compared++; if (regWrite !== !FAIR || rWriteAddress !== 5'd12 || rWriteValue !== 32'hB12) begin mismatched++; $display("[TB] FAIL full_drain2: got %0h/%0h/%0h, expected %0h/c/b12", regWrite, rWriteAddress, rWriteValue, !FAIR); end
        step();
        compared++; if (regWrite !== 1'b0 || mduReady !== 1'b1) begin mismatched++; $display("[TB] FAIL full_no_extra: got wr %0h ready %0h, expected 0/1", regWrite, mduReady); end
    endtask

    task automatic test_zero();
        clearInputs();
        mduIssue = 1; mduIssueAddr = 0;
        step();
        mduIssue = 0;
        compared++; if (hazStall !== 1'b0) begin mismatched++; $display("[TB] FAIL zero_issue: got %0h, expected 0", hazStall); end
        mduValid = 1; mduAddr = 0; mduData = 32'h55;
        step();
        mduAddr = 6; mduData = 32'h66;
        step();
        mduValid = 0;
        compared++; if (regWrite !== 1'b0) begin mismatched++; $display("[TB] FAIL zero_no_write: got %0h, expected 0", regWrite); end
        step();
        compared++; if (regWrite !== 1'b1 || rWriteAddress !== 5'd6 || rWriteValue !== 32'h66) begin mismatched++; $display("[TB] FAIL zero_popped: got %0h/%0h/%0h, expected 1/6/66", regWrite, rWriteAddress, rWriteValue); end
        step();
        compared++; if (regWrite !== 1'b0 || mduReady !== 1'b1) begin mismatched++; $display("[TB] FAIL zero_empty: got wr %0h ready %0h, expected 0/1", regWrite, mduReady); end
    endtask

    task automatic test_reset_mid();
        clearInputs();
        pipeValid = 1; pipeAddr = 1; pipeData = 32'hA1;
        mduIssue = 1; mduIssueAddr = 4; rs = 4;
        mduValid = 1; mduAddr = 4; mduData = 32'h44;
        step();
        mduIssue = 0;
        mduAddr = 8; mduData = 32'h88;
        step();
        mduValid = 0;
        compared++; if (hazStall !== 1'b1 || mduReady !== 1'b0) begin mismatched++; $display("[TB] FAIL rmid_pre: got haz %0h ready %0h, expected 1/0", hazStall, mduReady); end
        #2;
        rst = 1'b1;
        #1;
        compared++; if (regWrite !== 1'b0 || rWriteAddress !== 5'd0 || rWriteValue !== 32'd0) begin mismatched++; $display("[TB] FAIL rmid_async: got %0h/%0h/%0h, expected 0/0/0", regWrite, rWriteAddress, rWriteValue); end
        compared++; if (mduReady !== 1'b1 || hazStall !== 1'b0) begin mismatched++; $display("[TB] FAIL rmid_state: got ready %0h haz %0h, expected 1/0", mduReady, hazStall); end
        step();
        rst = 1'b0;
        pipeValid = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            compared++; if (regWrite !== 1'b0 || hazStall !== 1'b0) begin mismatched++; $display("[TB] FAIL rmid_after_%0d: got wr %0h haz %0h, expected 0/0", i, regWrite, hazStall); end
        end
    endtask

    initial begin
        $display("[TB] wb_arbiter bench, DEPTH=%0d fairness=%0d", DEPTH, FAIR);
        clearInputs();
        test_reset();
        test_mdu_write();
        test_priority();
        test_hazard();
        test_full();
        test_zero();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
